gcd_callee: RTL and testbench
=============================

Name: gcd_callee

Overview:
- Compiled-function callee: computes gcd(a, b) by iterative subtraction under the team's start/done call protocol.
- Sits directly downstream of a caller function module. The caller latches arguments, pulses `start` for one cycle, waits for `done`, then captures `result`.
- Port names match the caller's instantiation list so it drops in as the callee instance.

Parameters:
- WIDTH, 32, data width of a, b, result and internal operand registers.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  call request; sampled only in IDLE.
- result  output  WIDTH  gcd value; held until the next FINISH or reset.
- done  output  1  high = idle with valid result; low = busy.
- a  input  WIDTH  first argument; sampled in LATCH.
- b  input  WIDTH  second argument; sampled in LATCH.

Behaviour:
- Reset (sync, active-high) clears state to IDLE and sets result=0, done=0 and internal x=0, y=0. Reset mid-computation aborts the computation; no result is produced.
- State register is WIDTH-wide, in the same style as the caller. Encodings: IDLE=0, LATCH=1, LOOP=2, FINISH=3.
- IDLE:
  - start=1: state<=LATCH and done<=0 on that same edge. The caller's one-cycle pulse must see done low at its next wait-state sample.
  - start=0: state stays IDLE, done<=1.
- LATCH: x<=a, y<=b, state<=LOOP. Arguments are sampled here only; later changes on a/b are ignored.
- LOOP, one comparison per cycle, priority in this order:
  - x==0: x<=y, state<=FINISH.
  - y==0 or x==y: state<=FINISH.
  - x>y: x<=x-y.
  - x<y: y<=y-x.
- FINISH: result<=x, done<=1, state<=IDLE.
- Boundary results: gcd(0,0)=0; gcd(0,n)=n; gcd(n,0)=n.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - Subtraction is only ever taken when the minuend is larger, so it never wraps.
- Latency: start high at IDLE edge E gives LATCH at E+1, first LOOP at E+2, FINISH at E+2+k, where k is the number of LOOP cycles including the terminating one. done=1 and result are valid after edge E+3+k.
- Worst case: k = 2^WIDTH-1, e.g. (max,1). No iteration limit.
- start is ignored outside IDLE; done stays 0 while busy.
- start held high continuously: a new call is accepted on every IDLE visit. done pulses high only for the cycle after FINISH, then drops when IDLE accepts the next call.
- result is never cleared by a new call; only FINISH or reset updates it.

Decomposition:
- Shared package holds the state encodings (IDLE/LATCH/LOOP/FINISH), the state-width constant and the common call-protocol constants. Every compiled function module uses them.
- No sub-module. The compare/subtract datapath is a few lines inline; splitting it out adds no value.

Test Plan:
- Reset: hold reset 2 cycles, then start=0 → result=0 and done=0 during reset; done=1 one edge after release.
- a=12, b=18, one-cycle start → done low next edge. LOOP path (12,18)→(12,6)→(6,6), k=3. done=1 with result=6 at edge E+6.
- a=0, b=7 → result=7 with k=1. a=9, b=0 → result=9. a=0, b=0 → result=0.
- a=5, b=5 → result=5 after exactly 4 edges from the start edge. Change a/b after LATCH → result unchanged.
- Reset asserted in LOOP with a=100, b=1 → IDLE with result=0, done=0. A new call with a=8, b=12 completes with result=4.
- Back-to-back: caller-style sequence of start pulse, wait for done, capture result, repeated for (21,14)→7 then (17,5)→1. Extra start pulses while busy have no effect.

Source files
------------

// File: rtl/gcd_callee_pkg.sv
// Shared call-protocol definitions for compiled-function modules:
// state encodings, state-width constant and start/done handshake levels.
package gcd_callee_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_LATCH  = 2'd1,
        ST_LOOP   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    // done level while a call is in flight vs. idle with a valid result
    localparam logic DONE_BUSY  = 1'b0;
    localparam logic DONE_READY = 1'b1;
    localparam logic START_CALL = 1'b1;

endpackage

// File: rtl/gcd_callee.sv
// Callee for gcd(a, b) by repeated subtraction under the start/done call protocol.
// The state register is WIDTH bits wide to match the caller's own state register.
module gcd_callee
    import gcd_callee_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             done,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b
);

    localparam logic [WIDTH-1:0] S_IDLE   = WIDTH'(ST_IDLE);
    localparam logic [WIDTH-1:0] S_LATCH  = WIDTH'(ST_LATCH);
    localparam logic [WIDTH-1:0] S_LOOP   = WIDTH'(ST_LOOP);
    localparam logic [WIDTH-1:0] S_FINISH = WIDTH'(ST_FINISH);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;

    // Call FSM with inline compare/subtract datapath; done and result are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            x_r     <= ZERO;
            y_r     <= ZERO;
            result  <= ZERO;
            done    <= DONE_BUSY;
        end else begin
            case (state_r)
                S_IDLE: begin
                    // done must fall on the accepting edge so the caller never sees a stale done
                    if (start == START_CALL) begin
                        state_r <= S_LATCH;
                        done    <= DONE_BUSY;
                    end else begin
                        done    <= DONE_READY;
                    end
                end
                S_LATCH: begin
                    x_r     <= a;
                    y_r     <= b;
                    state_r <= S_LOOP;
                end
                S_LOOP: begin
                    // x==0 first so gcd(0,n)=n; subtraction only runs with the larger operand as minuend
                    if (x_r == ZERO) begin
                        x_r     <= y_r;
                        state_r <= S_FINISH;
                    end else if ((y_r == ZERO) || (x_r == y_r)) begin
                        state_r <= S_FINISH;
                    end else if (x_r > y_r) begin
                        x_r <= x_r - y_r;
                    end else begin
                        y_r <= y_r - x_r;
                    end
                end
                S_FINISH: begin
                    result  <= x_r;
                    done    <= DONE_READY;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    done    <= DONE_BUSY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_callee.sv
// Directed bench for gcd_callee: reset, exact call latency, boundary operands,
// argument isolation after LATCH, mid-call reset and caller-style back-to-back calls.
module tb_gcd_callee;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] result;
    logic         done;
    logic [W-1:0] a;
    logic [W-1:0] b;

    int tests;
    int fails;

    gcd_callee #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .result (result),
        .done   (done),
        .a      (a),
        .b      (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // start is driven just after edge E; done must be low from E+1 through E+2+k, high at E+3+k.
    task automatic exact_call(input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic [W-1:0] exp, input int k, input string tag);
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_done_fall"}, {31'd0, done}, 32'd0);
        tick();
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        for (int i = 3; i <= 2 + k; i++) begin
            tick();
            check({tag, "_busy"}, {31'd0, done}, 32'd0);
        end
        tick();
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_result"}, result, exp);
    endtask

    // Caller-style call with a stray start pulse while busy and a bounded wait for done.
    task automatic caller_call(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [W-1:0] exp, input string tag);
        int n;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_done_fall"}, {31'd0, done}, 32'd0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_done_in_budget"}, {31'd0, done}, 32'd1);
        check({tag, "_result"}, result, exp);
        tick();
        check({tag, "_stays_idle"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        start = 1'b0;
        a = 32'd0;
        b = 32'd0;

        tick();
        tick();
        check("reset_result", result, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        tick();
        check("release_done", {31'd0, done}, 32'd1);
        check("release_result", result, 32'd0);

        exact_call(32'd12, 32'd18, 32'd6, 3, "gcd_12_18");
        exact_call(32'd0,  32'd7,  32'd7, 1, "gcd_0_7");
        exact_call(32'd9,  32'd0,  32'd9, 1, "gcd_9_0");
        exact_call(32'd0,  32'd0,  32'd0, 1, "gcd_0_0");
        exact_call(32'd5,  32'd5,  32'd5, 1, "gcd_5_5");

        // abort a long call while it is iterating
        a = 32'd100;
        b = 32'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort_result", result, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        tick();
        check("abort_idle_done", {31'd0, done}, 32'd1);
        check("abort_idle_result", result, 32'd0);
        exact_call(32'd8, 32'd12, 32'd4, 3, "gcd_8_12");

        caller_call(32'd21, 32'd14, 32'd7, "b2b_21_14");
        caller_call(32'd17, 32'd5,  32'd1, "b2b_17_5");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
